// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared widths and FSM state type for the partial-sum accumulator/quantizer
package cim_pkg;

    localparam int N_LANE = 8;
    localparam int IN_W   = 18;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 4;
    localparam int CNT_W  = 6;
    localparam int SH_W   = 5;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        QNT = 2'd1,
        OUT = 2'd2
    } state_t;

endpackage

// File: rtl/quant_lane.sv
// rtl/quant_lane.sv - round, arithmetic-shift and saturate one accumulator lane to OUT_W bits
// PSUM_RELU_EN selects unsigned ReLU clamp [0,15] instead of signed clamp [-8,7].
module quant_lane
    import cim_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc,
    input  logic [SH_W-1:0]         shift,
    output logic [OUT_W-1:0]        q
);

    // One guard bit so the rounding add can never wrap.
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shr;

    always_comb begin
        rnd = '0;
        if (shift != '0) begin
            rnd = {{ACC_W{1'b0}}, 1'b1} << (shift - SH_W'(1));
        end
        sum = {acc[ACC_W-1], acc} + rnd;
        shr = sum >>> shift;
    end

`ifdef PSUM_RELU_EN
    localparam logic signed [ACC_W:0] U_MAX = (ACC_W+1)'(2**OUT_W - 1);

    always_comb begin
        if (shr[ACC_W]) begin
            q = '0;
        end else if (shr > U_MAX) begin
            q = U_MAX[OUT_W-1:0];
        end else begin
            q = shr[OUT_W-1:0];
        end
    end
`else
    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] Q_MIN = -(ACC_W+1)'(2**(OUT_W-1));

    always_comb begin
        if (shr > Q_MAX) begin
            q = Q_MAX[OUT_W-1:0];
        end else if (shr < Q_MIN) begin
            q = Q_MIN[OUT_W-1:0];
        end else begin
            q = shr[OUT_W-1:0];
        end
    end
`endif

endmodule

// File: rtl/psum_accum_quant.sv
// rtl/psum_accum_quant.sv - accumulate num_tiles beats of 8 partial-sum lanes, requantize to 4b each
// Optional macro PSUM_RELU_EN (in quant_lane) switches output lanes to unsigned ReLU.
module psum_accum_quant
    import cim_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_LANE*IN_W-1:0]    in_data,
    input  logic [CNT_W-1:0]          cfg_num_tiles,
    input  logic [SH_W-1:0]           cfg_shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_LANE*OUT_W-1:0]   out_data,
    output logic                      busy
);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]        tile_cnt;
    logic [CNT_W-1:0]        num_tiles_q;
    logic [CNT_W-1:0]        cfg_tiles_eff;
    logic [CNT_W-1:0]        cur_tiles;
    logic [SH_W-1:0]         shift_q;
    logic signed [ACC_W-1:0] acc      [N_LANE];
    logic signed [ACC_W-1:0] lane_ext [N_LANE];
    logic [N_LANE*OUT_W-1:0] q_all;
    logic                    beat;
    logic                    last_beat;

    assign in_ready      = (state == ACC) && !rst;
    assign beat          = in_valid && in_ready;
    assign cfg_tiles_eff = (cfg_num_tiles == '0) ? CNT_W'(1) : cfg_num_tiles;
    // The first beat of a group must judge "last" from live config; later beats use the latched copy.
    assign cur_tiles     = (tile_cnt == '0) ? cfg_tiles_eff : num_tiles_q;
    assign last_beat     = (tile_cnt == cur_tiles - CNT_W'(1));
    assign busy          = (tile_cnt != '0) || (state != ACC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (beat && last_beat) state_nxt = QNT;
            QNT:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_cnt    <= '0;
            num_tiles_q <= '0;
            shift_q     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            for (int i = 0; i < N_LANE; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (beat) begin
                if (tile_cnt == '0) begin
                    num_tiles_q <= cfg_tiles_eff;
                    shift_q     <= cfg_shift;
                end
                for (int i = 0; i < N_LANE; i++) begin
                    if (tile_cnt == '0) begin
                        acc[i] <= lane_ext[i];
                    end else begin
                        acc[i] <= acc[i] + lane_ext[i];
                    end
                end
                tile_cnt <= last_beat ? '0 : tile_cnt + CNT_W'(1);
            end
            if (state == QNT) begin
                out_data  <= q_all;
                out_valid <= 1'b1;
            end else if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_LANE; g++) begin : g_lane
        assign lane_ext[g] = {{(ACC_W-IN_W){in_data[g*IN_W+IN_W-1]}}, in_data[g*IN_W +: IN_W]};

        quant_lane u_quant (
            .acc   (acc[g]),
            .shift (shift_q),
            .q     (q_all[g*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_psum_accum_quant.sv
// tb/tb_psum_accum_quant.sv - directed and randomized checks of psum_accum_quant against an arithmetic model
module tb_psum_accum_quant;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [143:0] in_data;
    logic [5:0]   cfg_num_tiles;
    logic [4:0]   cfg_shift;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         busy;

    int total = 0;
    int bad   = 0;

    longint      m_acc [8];
    int          m_cnt;
    int          m_tiles;
    int          m_shift;
    logic [31:0] exp_q [$];
    logic [31:0] last_out;

    psum_accum_quant dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .cfg_num_tiles (cfg_num_tiles),
        .cfg_shift     (cfg_shift),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint lane_val(input logic [143:0] d, input int i);
        logic [17:0] v;
        v = d[i*18 +: 18];
        return longint'($signed(v));
    endfunction

    // Round-half-up then floor-divide by 2^sh, then clamp to the output range.
    function automatic logic [3:0] quant(input longint a, input int sh);
        longint x, d, r;
        x = a + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0);
        d = longint'(1) << sh;
        r = x / d;
        if ((x % d) != 0 && x < 0) r = r - 1;
`ifdef PSUM_RELU_EN
        if (r < 0) r = 0;
        if (r > 15) r = 15;
`else
        if (r > 7) r = 7;
        if (r < -8) r = -8;
`endif
        return r[3:0];
    endfunction

    function automatic logic [143:0] all_lanes(input int v);
        logic [143:0] d;
        for (int i = 0; i < 8; i++) d[i*18 +: 18] = v[17:0];
        return d;
    endfunction

    function automatic logic [143:0] lane0_only(input int v);
        logic [143:0] d;
        d = '0;
        d[17:0] = v[17:0];
        return d;
    endfunction

    function automatic logic [143:0] rand_data(input int mag_bits);
        logic [143:0] d;
        logic [31:0]  r;
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            r = (mag_bits >= 17) ? r : {{15{r[mag_bits]}}, r[16:0]} & ((32'h1 << (mag_bits + 1)) - 1 | {15{r[mag_bits]}} << 17);
            d[i*18 +: 18] = r[17:0];
        end
        return d;
    endfunction

    task automatic model_accept(input logic [143:0] d);
        logic [31:0] e;
        if (m_cnt == 0) begin
            m_tiles = (cfg_num_tiles == 0) ? 1 : int'(cfg_num_tiles);
            m_shift = int'(cfg_shift);
            for (int i = 0; i < 8; i++) m_acc[i] = lane_val(d, i);
        end else begin
            for (int i = 0; i < 8; i++) m_acc[i] = m_acc[i] + lane_val(d, i);
        end
        if (m_cnt == m_tiles - 1) begin
            m_cnt = 0;
            for (int i = 0; i < 8; i++) e[i*4 +: 4] = quant(m_acc[i], m_shift);
            exp_q.push_back(e);
        end else begin
            m_cnt++;
        end
    endtask

    task automatic send_beat(input string tag, input logic [143:0] d);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk({tag, "_ready_timeout"}, {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        model_accept(d);
        #1;
        in_valid = 1'b0;
    endtask

    // Called 1ns after the edge that accepted the last beat of a group.
    task automatic collect(input string tag, input int hold);
        logic [31:0] e;
        e = '0;
        if (exp_q.size() == 0) chk({tag, "_model_empty"}, 32'h0, 32'h1);
        else e = exp_q.pop_front();
        chk({tag, "_qnt_valid_low"}, {31'b0, out_valid}, 32'h0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
        chk({tag, "_data"}, out_data, e);
        chk({tag, "_in_ready_low"}, {31'b0, in_ready}, 32'h0);
        last_out = out_data;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_data"}, out_data, e);
            chk({tag, "_hold_valid"}, {31'b0, out_valid}, 32'h1);
            chk({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'b0, out_valid}, 32'h0);
    endtask

    initial begin
        logic [143:0] d;
        int           tiles, gaps;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        cfg_num_tiles = '0;
        cfg_shift = '0;
        out_ready = 1'b0;
        m_cnt = 0;
        m_tiles = 1;
        m_shift = 0;
        last_out = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

        // T1 single tile
        cfg_num_tiles = 6'd1; cfg_shift = 5'd0;
        send_beat("t1", all_lanes(5));
        collect("t1", 0);
        chk("t1_const", last_out, 32'h55555555);

        // T2 three-tile accumulate with rounding shift
        cfg_num_tiles = 6'd3; cfg_shift = 5'd2;
        send_beat("t2", lane0_only(10));
        chk("t2_busy", {31'b0, busy}, 32'h1);
        send_beat("t2", lane0_only(20));
        send_beat("t2", lane0_only(30));
        collect("t2", 0);
`ifdef PSUM_RELU_EN
        chk("t2_const", last_out, 32'h0000000F);
`else
        chk("t2_const", last_out, 32'h00000007);
`endif

        // T3 negative value with rounding
        cfg_num_tiles = 6'd1; cfg_shift = 5'd3;
        send_beat("t3", lane0_only(-13));
        collect("t3", 0);
`ifdef PSUM_RELU_EN
        chk("t3_const", last_out, 32'h00000000);
`else
        chk("t3_const", last_out, 32'h0000000E);
`endif

        // T4 backpressure, then a held beat accepted one cycle after the handshake
        cfg_num_tiles = 6'd1; cfg_shift = 5'd0;
        send_beat("t4", all_lanes(-3));
        begin
            logic [31:0] e4;
            e4 = exp_q.pop_front();
            chk("t4_qnt_valid_low", {31'b0, out_valid}, 32'h0);
            @(posedge clk); #1;
            chk("t4_valid", {31'b0, out_valid}, 32'h1);
            chk("t4_data", out_data, e4);
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                chk("t4_stall_data", out_data, e4);
                chk("t4_stall_in_ready", {31'b0, in_ready}, 32'h0);
            end
            d = all_lanes(2);
            in_data = d;
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("t4_handshake_valid_drop", {31'b0, out_valid}, 32'h0);
            chk("t4_ready_after_hs", {31'b0, in_ready}, 32'h1);
            @(posedge clk);
            model_accept(d);
            #1;
            in_valid = 1'b0;
            chk("t4_accepted_next", {31'b0, in_ready}, 32'h0);
            collect("t4b", 0);
        end

        // T5 reset mid-group discards partial state
        cfg_num_tiles = 6'd4; cfg_shift = 5'd0;
        send_beat("t5", all_lanes(100));
        send_beat("t5", all_lanes(100));
        chk("t5_busy_mid", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t5_rst_in_ready", {31'b0, in_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 0;
        exp_q.delete();
        chk("t5_busy_cleared", {31'b0, busy}, 32'h0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("t5_no_valid", {31'b0, out_valid}, 32'h0);
        end
        cfg_num_tiles = 6'd1; cfg_shift = 5'd0;
        send_beat("t5b", lane0_only(3));
        collect("t5b", 0);
        chk("t5_const", last_out, 32'h00000003);

        // T6 mid-group shift change ignored; num_tiles=0 means one tile; 63-tile extreme
        cfg_num_tiles = 6'd2; cfg_shift = 5'd1;
        send_beat("t6a", all_lanes(9));
        cfg_shift = 5'd6;
        send_beat("t6a", all_lanes(4));
        collect("t6a", 0);
        chk("t6a_const", last_out, 32'h77777777);

        cfg_num_tiles = 6'd0; cfg_shift = 5'd0;
        send_beat("t6b", lane0_only(-2));
        collect("t6b", 0);

        cfg_num_tiles = 6'd63; cfg_shift = 5'd0;
        for (int b = 0; b < 63; b++) send_beat("t6c", all_lanes(-131072));
        chk("t6c_model_acc", m_acc[0][31:0], 32'(-8257536));
        collect("t6c", 0);
`ifdef PSUM_RELU_EN
        chk("t6c_const", last_out, 32'h00000000);
`else
        chk("t6c_const", last_out, 32'h88888888);
`endif

        // Randomized groups with idle gaps and backpressure
        for (int g = 0; g < 12; g++) begin
            tiles = $urandom_range(1, 5);
            cfg_num_tiles = 6'(tiles);
            cfg_shift = 5'($urandom_range(0, 23));
            for (int b = 0; b < tiles; b++) begin
                gaps = $urandom_range(0, 2);
                repeat (gaps) begin
                    @(posedge clk); #1;
                end
                d = rand_data($urandom_range(3, 17));
                send_beat("rnd", d);
                if (b == 0) cfg_shift = 5'($urandom_range(0, 23));
            end
            collect("rnd", $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
